pipeline_hazard_control: RTL

// - Per-stage pipeline clear/pause generator; generalises the single jump -> clear/pause decode.
// - Sits beside the PC and inter-stage registers. Combines a jump redirect from any stage with
//   per-stage stall requests, resolves priority, and holds the flush for a programmable

---
 rtl/pipeline_hazard_control_pkg.sv | 24 ++
 rtl/pipeline_hazard_control_stall_prio_enc.sv | 22 ++
 rtl/pipeline_hazard_control.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_control_pkg.sv
// Shared types and signal levels for the pipeline hazard controller.
// Used by pipeline_hazard_control and its stall priority encoder.
package pipeline_hazard_control_pkg;

  typedef enum logic {
    HZ_IDLE  = 1'b0,
    HZ_FLUSH = 1'b1
  } hz_state_e;

  localparam logic CLEAR_ENABLE    = 1'b1;
  localparam logic CLEAR_DISABLE   = 1'b0;
  localparam logic PAUSE_ENABLE    = 1'b1;
  localparam logic PAUSE_DISABLE   = 1'b0;
  localparam logic PC_JUMP_ENABLE  = 1'b1;
  localparam logic PC_JUMP_DISABLE = 1'b0;

  localparam int STAT_W = 32;

  // Saturating increment for the optional statistics counters.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + {{(STAT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/pipeline_hazard_control_stall_prio_enc.sv
// Highest-set-index encoder over the per-stage stall requests.
// valid is the OR of all requests; idx is the oldest requesting stage.
module pipeline_hazard_control_stall_prio_enc #(
  parameter int N  = 5,
  parameter int SW = 3
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [SW-1:0] idx
);

  assign valid = |req;

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) idx = SW'(i);
    end
  end

endmodule

// File: rtl/pipeline_hazard_control.sv
// Per-stage clear/pause generator: jump redirect vs. stall priority plus a
// multi-cycle flush window. Optional counters enabled by HAZARD_STATS_EN.
module pipeline_hazard_control
  import pipeline_hazard_control_pkg::*;
#(
  parameter  int NUM_STAGES   = 5,
  parameter  int FLUSH_CYCLES = 3,
  localparam int SW           = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pc_jump_en,
  input  logic [SW-1:0]         jump_stage,
  input  logic [NUM_STAGES-1:0] stall_req,
  output logic [NUM_STAGES-1:0] clear,
  output logic [NUM_STAGES-1:0] pause,
  output logic                  pc_pause,
`ifdef HAZARD_STATS_EN
  output logic [STAT_W-1:0]     flush_cnt,
  output logic [STAT_W-1:0]     stall_cnt,
`endif
  output logic                  busy
);

  localparam int CW       = $clog2(FLUSH_CYCLES + 1);
  localparam bit FLUSH_EN = (FLUSH_CYCLES > 1);

  hz_state_e       state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [SW-1:0]   jstage_reg, jstage_next;

  logic            stall_valid;
  logic [SW-1:0]   s_max;
  logic [SW:0]     s_above;
  logic [SW-1:0]   j_eff;
  logic            jump_acc;

  logic [NUM_STAGES-1:0] jump_mask, flush_mask, stall_pause, stall_clear;

  pipeline_hazard_control_stall_prio_enc #(
    .N  (NUM_STAGES),
    .SW (SW)
  ) u_stall_prio_enc (
    .req   (stall_req),
    .valid (stall_valid),
    .idx   (s_max)
  );

  // Stage 0 (IF) cannot resolve a jump, so it is treated like out-of-range.
  assign j_eff = (jump_stage == '0 || int'(jump_stage) > NUM_STAGES - 1)
                 ? SW'(NUM_STAGES - 1) : jump_stage;

  assign jump_acc = (pc_jump_en == PC_JUMP_ENABLE) && (!stall_valid || j_eff >= s_max);

  // One wider than s_max so the stage above the oldest stall never wraps to 0.
  assign s_above = {1'b0, s_max} + {{SW{1'b0}}, 1'b1};

  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_mask
    assign jump_mask[gi]   = (SW'(gi) < j_eff)      ? CLEAR_ENABLE : CLEAR_DISABLE;
    assign flush_mask[gi]  = (SW'(gi) < jstage_reg) ? CLEAR_ENABLE : CLEAR_DISABLE;
    assign stall_pause[gi] = (stall_valid && SW'(gi) <= s_max) ? PAUSE_ENABLE : PAUSE_DISABLE;
    assign stall_clear[gi] = (stall_valid && (SW + 1)'(gi) == s_above) ? CLEAR_ENABLE : CLEAR_DISABLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= HZ_IDLE;
      cnt_reg    <= '0;
      jstage_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      jstage_reg <= jstage_next;
    end
  end

  // An accepted jump (re)starts the window whether idle or already flushing.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    jstage_next = jstage_reg;
    if (jump_acc && FLUSH_EN) begin
      state_next  = HZ_FLUSH;
      cnt_next    = CW'(FLUSH_CYCLES - 1);
      jstage_next = j_eff;
    end else if (state_reg == HZ_FLUSH) begin
      if (cnt_reg <= CW'(1)) begin
        state_next = HZ_IDLE;
        cnt_next   = '0;
      end else begin
        cnt_next = cnt_reg - CW'(1);
      end
    end
  end

  always_comb begin
    clear    = '0;
    pause    = '0;
    pc_pause = PAUSE_DISABLE;
    busy     = 1'b0;
    if (rst_n) begin
      busy = (state_reg == HZ_FLUSH);
      if (jump_acc) begin
        clear = jump_mask;
      end else begin
        if (stall_valid) begin
          pause    = stall_pause;
          clear    = stall_clear;
          pc_pause = PAUSE_ENABLE;
        end
        if (state_reg == HZ_FLUSH) begin
          clear    = clear | flush_mask;
          pc_pause = PAUSE_ENABLE;
        end
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] flush_cnt_reg, stall_cnt_reg;
  logic              flush_hit, stall_hit;

  assign flush_hit = (jump_acc && |jump_mask) ||
                     (!jump_acc && state_reg == HZ_FLUSH && |flush_mask);
  assign stall_hit = stall_valid && !jump_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt_reg <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (flush_hit) flush_cnt_reg <= sat_inc(flush_cnt_reg);
      if (stall_hit) stall_cnt_reg <= sat_inc(stall_cnt_reg);
    end
  end

  assign flush_cnt = flush_cnt_reg;
  assign stall_cnt = stall_cnt_reg;
`endif

endmodule
